// File: rtl/std_dev_pkg.sv
// -----------------------------------------------------------------------------
// std_dev_pkg
// Shared constants and elaboration-time helpers for the standard-deviation
// engine. Widths depend on the lane count and sample width, so they are
// exposed as constant functions that the modules evaluate from their own
// parameters.
//   clog2     : ceiling log2, used to size the square-sum accumulator
//   accWidth  : accumulator width, 2*SIZE + clog2(N_INPUT)
//   radWidth  : square-root radicand width, 2*SIZE
//   latency   : input-to-output latency in cycles, SIZE + 3
//   isPow2    : selects shift versus constant divide for the variance
// -----------------------------------------------------------------------------
package std_dev_pkg;

  localparam int DEFAULT_N_INPUT = 8;
  localparam int DEFAULT_SIZE    = 32;

  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result = result + 1;
      rest   = rest >> 1;
    end
    return result;
  endfunction

  // Sum of N_INPUT squares of SIZE-bit values cannot exceed this width.
  function automatic int accWidth(input int size, input int nInput);
    return 2 * size + clog2(nInput);
  endfunction

  function automatic int radWidth(input int size);
    return 2 * size;
  endfunction

  // Three arithmetic stages plus one stage per result bit of the root.
  function automatic int latency(input int size);
    return size + 3;
  endfunction

  function automatic bit isPow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/isqrt_pipe.sv
// -----------------------------------------------------------------------------
// isqrt_pipe
// Fully pipelined restoring integer square root, one result bit per stage,
// MSB first. Accepts a new radicand every cycle; the floor square root
// appears W cycles later.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset, clears every stage
//   radicand_i : 2*W-bit unsigned radicand
//   root_o     : W-bit registered floor(sqrt(radicand))
// -----------------------------------------------------------------------------
module isqrt_pipe #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2*W-1:0] radicand_i,
  output logic [W-1:0]   root_o
);

  // Registered state between stage k-1 and stage k, for k = 1..W-1.
  // The remainder never exceeds twice the partial root, so W+2 bits hold it
  // even after the two-bit left shift at the start of each stage.
  logic [W+1:0]   rem_q  [1:W-1];
  logic [W-1:0]   root_q [1:W-1];
  logic [2*W-1:0] rad_q  [1:W-1];

  logic [W+1:0]   rem_d  [1:W-1];
  logic [W-1:0]   root_d [1:W-1];
  logic [2*W-1:0] rad_d  [1:W-1];
  logic [W-1:0]   rootLast_d;

  // Each stage brings down the next two radicand bits, tries to subtract
  // 4*root+1, and appends a 1 to the root when the subtraction fits.
  // The radicand is shifted left as it travels so its top two bits are
  // always the pair that the current stage consumes.
  for (genvar k = 0; k < W; k++) begin : g_stage
    logic [W+1:0]   remIn;
    logic [W-1:0]   rootIn;
    logic [2*W-1:0] radIn;
    logic [W+1:0]   remShift;
    logic [W+1:0]   trial;
    logic           take;

    if (k == 0) begin : g_first
      assign remIn  = '0;
      assign rootIn = '0;
      assign radIn  = radicand_i;
    end else begin : g_next
      assign remIn  = rem_q[k];
      assign rootIn = root_q[k];
      assign radIn  = rad_q[k];
    end

    assign remShift = (remIn << 2) | (W+2)'(radIn >> (2*W-2));
    assign trial    = {rootIn, 2'b01};
    assign take     = (remShift >= trial);

    if (k < W - 1) begin : g_carry
      assign rem_d[k+1]  = take ? (remShift - trial) : remShift;
      assign root_d[k+1] = (rootIn << 1) | W'(take);
      assign rad_d[k+1]  = radIn << 2;
    end else begin : g_last
      assign rootLast_d = (rootIn << 1) | W'(take);
    end
  end

  // All stage registers, including the final root, share one reset domain
  // so an asserted reset flushes every in-flight result at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k < W; k++) begin
        rem_q[k]  <= '0;
        root_q[k] <= '0;
        rad_q[k]  <= '0;
      end
      root_o <= '0;
    end else begin
      for (int k = 1; k < W; k++) begin
        rem_q[k]  <= rem_d[k];
        root_q[k] <= root_d[k];
        rad_q[k]  <= rad_d[k];
      end
      root_o <= rootLast_d;
    end
  end

endmodule

// File: rtl/std_dev_core.sv
// -----------------------------------------------------------------------------
// std_dev_core
// Fully pipelined population standard deviation about an externally supplied
// mean. One new sample vector per clock; result after SIZE+3 cycles.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset, clears the whole pipeline
//   in_data : N_INPUT packed unsigned samples, lane 0 in the MSBs
//   mean    : unsigned mean of the samples, computed upstream
//   std_dev : registered floor(sqrt(floor(sum((xi-mean)^2) / N_INPUT)))
// -----------------------------------------------------------------------------
module std_dev_core
  import std_dev_pkg::*;
#(
  parameter int N_INPUT = DEFAULT_N_INPUT,
  parameter int SIZE    = DEFAULT_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_INPUT*SIZE-1:0] in_data,
  input  logic [SIZE-1:0]         mean,
  output logic [SIZE-1:0]         std_dev
);

  localparam int ACC_W = accWidth(SIZE, N_INPUT);
  localparam int RAD_W = radWidth(SIZE);
  localparam int SHIFT = clog2(N_INPUT);

  logic [SIZE-1:0]  absDiff_d [N_INPUT];
  logic [SIZE-1:0]  absDiff_q [N_INPUT];
  logic [RAD_W-1:0] square    [N_INPUT];
  logic [ACC_W-1:0] sumSq_d;
  logic [ACC_W-1:0] sumSq_q;
  logic [RAD_W-1:0] variance_d;
  logic [RAD_W-1:0] variance_q;

  // Per-lane unpacking and absolute difference. Subtracting the smaller
  // operand from the larger keeps the result exact for a mean on either
  // side of the sample, with no wrap-around.
  for (genvar i = 0; i < N_INPUT; i++) begin : g_lane
    logic [SIZE-1:0] sample;
    assign sample       = in_data[(N_INPUT-1-i)*SIZE +: SIZE];
    assign absDiff_d[i] = (sample >= mean) ? (sample - mean) : (mean - sample);
    assign square[i]    = RAD_W'(absDiff_q[i]) * RAD_W'(absDiff_q[i]);
  end

  // Square-sum across lanes; the accumulator carries clog2(N_INPUT) guard
  // bits above the square width so the total never overflows.
  always_comb begin
    sumSq_d = '0;
    for (int i = 0; i < N_INPUT; i++) begin
      sumSq_d = sumSq_d + ACC_W'(square[i]);
    end
  end

  // Variance, truncated toward zero. A power-of-two lane count reduces to
  // a shift; the quotient always fits the radicand width because the
  // variance cannot exceed the largest single square.
  if (isPow2(N_INPUT)) begin : g_shift
    assign variance_d = RAD_W'(sumSq_q >> SHIFT);
  end else begin : g_divide
    assign variance_d = RAD_W'(sumSq_q / ACC_W'(N_INPUT));
  end

  // Front three pipeline stages: difference, square-sum, variance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_INPUT; i++) begin
        absDiff_q[i] <= '0;
      end
      sumSq_q    <= '0;
      variance_q <= '0;
    end else begin
      for (int i = 0; i < N_INPUT; i++) begin
        absDiff_q[i] <= absDiff_d[i];
      end
      sumSq_q    <= sumSq_d;
      variance_q <= variance_d;
    end
  end

  // SIZE further stages resolve the root; its last stage is the output
  // register.
  isqrt_pipe #(
    .W(SIZE)
  ) u_isqrt (
    .clk       (clk),
    .reset     (reset),
    .radicand_i(variance_q),
    .root_o    (std_dev)
  );

endmodule

// File: tb/tb_std_dev_core.sv
// -----------------------------------------------------------------------------
// tb_std_dev_core
// Directed bench for std_dev_core with N_INPUT=8, SIZE=32. A reference model
// computes each expected result with plain wide arithmetic and a binary
// search root, then delays it by the pipeline latency; a compare process
// checks the DUT against it every cycle. Hand-computed values pin both the
// model and selected DUT outputs.
// -----------------------------------------------------------------------------
module tb_std_dev_core;

  localparam int N_INPUT = 8;
  localparam int SIZE    = 32;
  localparam int LATENCY = 35;

  localparam logic [N_INPUT*SIZE-1:0] CASE1 =
    {32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 32'd50};
  localparam logic [N_INPUT*SIZE-1:0] CASE2 =
    {32'd46, 32'd69, 32'd32, 32'd60, 32'd52, 32'd41, 32'd50, 32'd50};
  localparam logic [N_INPUT*SIZE-1:0] CASE3 =
    {32'd0, 32'd0, 32'd0, 32'd0, 32'd10, 32'd10, 32'd10, 32'd10};
  localparam logic [N_INPUT*SIZE-1:0] CASE4 =
    {32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF,
     32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
  localparam logic [SIZE-1:0] BIG_RESULT = 32'd3037000499;

  logic                    clk     = 1'b0;
  logic                    reset   = 1'b0;
  logic [N_INPUT*SIZE-1:0] in_data = CASE1;
  logic [SIZE-1:0]         mean    = 32'd50;
  logic [SIZE-1:0]         std_dev;

  int total = 0;
  int bad   = 0;

  logic [SIZE-1:0] expectQ[$];
  logic [SIZE-1:0] modelOut    = '0;
  bit              checkEnable = 1'b0;

  std_dev_core #(
    .N_INPUT(N_INPUT),
    .SIZE   (SIZE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .in_data(in_data),
    .mean   (mean),
    .std_dev(std_dev)
  );

  always #5 clk = ~clk;

  // Reference: exact sum of squared deviations in 70-bit arithmetic,
  // integer division, then the largest r with r*r <= variance.
  function automatic logic [SIZE-1:0] expectedStd(input logic [N_INPUT*SIZE-1:0] v,
                                                  input logic [SIZE-1:0] m);
    logic [69:0] acc, x, d, variance, lo, hi, mid;
    acc = '0;
    for (int i = 0; i < N_INPUT; i++) begin
      x   = 70'(v[(N_INPUT-1-i)*SIZE +: SIZE]);
      d   = (x >= 70'(m)) ? (x - 70'(m)) : (70'(m) - x);
      acc = acc + d * d;
    end
    variance = acc / 70'(N_INPUT);
    lo = '0;
    hi = 70'd1 << SIZE;
    while (hi - lo > 70'd1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid <= variance) lo = mid;
      else hi = mid;
    end
    return lo[SIZE-1:0];
  endfunction

  // Latency model: every sampled vector becomes visible LATENCY edges later;
  // reset discards everything in flight.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      expectQ.delete();
      modelOut <= '0;
    end else begin
      expectQ.push_back(expectedStd(in_data, mean));
      if (expectQ.size() >= LATENCY) modelOut <= expectQ.pop_front();
    end
  end

  always @(negedge clk) begin
    if (checkEnable) begin
      total++;
      if (std_dev !== modelOut) begin
        bad++;
        $display("[TB] FAIL cycle_compare t=%0t actual=%0d expected=%0d",
                 $time, std_dev, modelOut);
      end
    end
  end

  task automatic checkValue(input string name, input logic [SIZE-1:0] actual,
                            input logic [SIZE-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [SIZE-1:0] expected);
    checkValue(name, std_dev, expected);
  endtask

  task automatic applyStimulus(input logic [N_INPUT*SIZE-1:0] v,
                               input logic [SIZE-1:0] m);
    @(negedge clk);
    in_data = v;
    mean    = m;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Pin the reference model to hand-computed values.
    checkValue("model_case1", expectedStd(CASE1, 32'd50), 32'd0);
    checkValue("model_case2", expectedStd(CASE2, 32'd50), 32'd10);
    checkValue("model_case3", expectedStd(CASE3, 32'd5),  32'd5);
    checkValue("model_case4", expectedStd(CASE4, 32'd0),  BIG_RESULT);

    // Case 1 under reset, then released.
    checkEnable = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("during_reset", 32'd0);
    #2 reset = 1'b1;
    repeat (LATENCY) @(posedge clk);
    @(negedge clk);
    checkOutput("case1_equal_samples", 32'd0);

    // Case 2 with an exact latency boundary check.
    applyStimulus(CASE2, 32'd50);
    repeat (LATENCY - 1) @(posedge clk);
    @(negedge clk);
    checkOutput("case2_before_latency", 32'd0);
    @(negedge clk);
    checkOutput("case2_result", 32'd10);

    // Case 3: mean between the samples.
    applyStimulus(CASE3, 32'd5);
    repeat (LATENCY) @(posedge clk);
    @(negedge clk);
    checkOutput("case3_result", 32'd5);

    // Case 4: extreme values, no overflow.
    applyStimulus(CASE4, 32'd0);
    repeat (LATENCY) @(posedge clk);
    @(negedge clk);
    checkOutput("case4_result", BIG_RESULT);

    // Case 5: back-to-back vectors stream out in order.
    applyStimulus(CASE2, 32'd50);
    applyStimulus(CASE3, 32'd5);
    applyStimulus(CASE4, 32'd0);
    repeat (LATENCY - 2) @(posedge clk);
    @(negedge clk);
    checkOutput("stream_first", 32'd10);
    @(negedge clk);
    checkOutput("stream_second", 32'd5);
    @(negedge clk);
    checkOutput("stream_third", BIG_RESULT);

    // Case 6: reset twenty cycles into a new stream.
    applyStimulus(CASE2, 32'd50);
    applyStimulus(CASE3, 32'd5);
    applyStimulus(CASE4, 32'd0);
    repeat (17) @(negedge clk);
    checkOutput("before_midstream_reset", BIG_RESULT);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_immediate", 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("reset_held", 32'd0);
    in_data = CASE2;
    mean    = 32'd50;
    #2 reset = 1'b1;
    repeat (LATENCY - 1) @(posedge clk);
    @(negedge clk);
    checkOutput("after_release_no_stale", 32'd0);
    @(negedge clk);
    checkOutput("after_release_case2", 32'd10);

    repeat (2) @(negedge clk);
    checkEnable = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
